// File: rtl/axi_slave_ram.sv
// AXI slave endpoint backed by a word-addressed dual-port RAM.
// Write and read channels run independent FSMs and support FIXED/INCR bursts.
module axi_slave_ram #(
    parameter int          ID_W      = 3,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h10000000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            SLAVE_CLK,
    output logic            SLAVE_RSTN,
    input  logic [ID_W-1:0] SLAVE_WR_ADDR_ID,
    input  logic [31:0]     SLAVE_WR_ADDR,
    input  logic [7:0]      SLAVE_WR_ADDR_LEN,
    input  logic [1:0]      SLAVE_WR_ADDR_BURST,
    input  logic            SLAVE_WR_ADDR_VALID,
    output logic            SLAVE_WR_ADDR_READY,
    input  logic [31:0]     SLAVE_WR_DATA,
    input  logic [3:0]      SLAVE_WR_STRB,
    input  logic            SLAVE_WR_DATA_LAST,
    input  logic            SLAVE_WR_DATA_VALID,
    output logic            SLAVE_WR_DATA_READY,
    output logic [ID_W-1:0] SLAVE_WR_BACK_ID,
    output logic [1:0]      SLAVE_WR_BACK_RESP,
    output logic            SLAVE_WR_BACK_VALID,
    input  logic            SLAVE_WR_BACK_READY,
    input  logic [ID_W-1:0] SLAVE_RD_ADDR_ID,
    input  logic [31:0]     SLAVE_RD_ADDR,
    input  logic [7:0]      SLAVE_RD_ADDR_LEN,
    input  logic [1:0]      SLAVE_RD_ADDR_BURST,
    input  logic            SLAVE_RD_ADDR_VALID,
    output logic            SLAVE_RD_ADDR_READY,
    output logic [ID_W-1:0] SLAVE_RD_BACK_ID,
    output logic [31:0]     SLAVE_RD_DATA,
    output logic [1:0]      SLAVE_RD_DATA_RESP,
    output logic            SLAVE_RD_DATA_LAST,
    output logic            SLAVE_RD_DATA_VALID,
    input  logic            SLAVE_RD_DATA_READY
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:ADDR_W] == BASE_ADDR[31:ADDR_W];
    endfunction

    function automatic logic burst_ok(input logic [1:0] b);
        return (b == 2'b00) || (b == BURST_INCR);
    endfunction

    assign SLAVE_CLK  = clk;
    assign SLAVE_RSTN = ~rst;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // ---------------- write channel ----------------
    wr_state_t       wr_state;
    logic [ID_W-1:0] wr_id;
    logic [31:0]     wr_addr;
    logic [7:0]      wr_len;
    logic [7:0]      wr_cnt;
    logic [1:0]      wr_burst;
    logic            wr_dec;
    logic            wr_slv;

    logic wr_beat, wr_hit, wr_en, wr_end, wr_dec_n, wr_slv_n;

    assign wr_beat  = SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_READY;
    assign wr_hit   = in_range(wr_addr);
    assign wr_en    = wr_beat && wr_hit && burst_ok(wr_burst) && !rst;
    assign wr_end   = (wr_cnt == wr_len) || SLAVE_WR_DATA_LAST;
    assign wr_dec_n = wr_dec || !wr_hit;
    assign wr_slv_n = wr_slv || !burst_ok(wr_burst) ||
                      (SLAVE_WR_DATA_LAST != (wr_cnt == wr_len));

    // RAM is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (SLAVE_WR_STRB[b])
                    mem[wr_addr[ADDR_W-1:0]][8*b +: 8] <= SLAVE_WR_DATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state            <= W_IDLE;
            wr_id               <= '0;
            wr_addr             <= '0;
            wr_len              <= '0;
            wr_cnt              <= '0;
            wr_burst            <= '0;
            wr_dec              <= 1'b0;
            wr_slv              <= 1'b0;
            SLAVE_WR_ADDR_READY <= 1'b0;
            SLAVE_WR_DATA_READY <= 1'b0;
            SLAVE_WR_BACK_VALID <= 1'b0;
            SLAVE_WR_BACK_ID    <= '0;
            SLAVE_WR_BACK_RESP  <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (SLAVE_WR_ADDR_VALID && SLAVE_WR_ADDR_READY) begin
                        wr_id               <= SLAVE_WR_ADDR_ID;
                        wr_addr             <= SLAVE_WR_ADDR;
                        wr_len              <= SLAVE_WR_ADDR_LEN;
                        wr_burst            <= SLAVE_WR_ADDR_BURST;
                        wr_cnt              <= '0;
                        wr_dec              <= 1'b0;
                        wr_slv              <= 1'b0;
                        SLAVE_WR_ADDR_READY <= 1'b0;
                        SLAVE_WR_DATA_READY <= 1'b1;
                        wr_state            <= W_DATA;
                    end else begin
                        SLAVE_WR_ADDR_READY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_beat) begin
                        // Burst closes on the beat count or an early LAST.
                        if (wr_end) begin
                            SLAVE_WR_DATA_READY <= 1'b0;
                            SLAVE_WR_BACK_VALID <= 1'b1;
                            SLAVE_WR_BACK_ID    <= wr_id;
                            SLAVE_WR_BACK_RESP  <= wr_dec_n ? RESP_DECERR :
                                                   wr_slv_n ? RESP_SLVERR : RESP_OKAY;
                            wr_state            <= W_RESP;
                        end else begin
                            wr_cnt <= wr_cnt + 8'd1;
                            if (wr_burst == BURST_INCR)
                                wr_addr <= wr_addr + 32'd1;
                        end
                        wr_dec <= wr_dec_n;
                        wr_slv <= wr_slv_n;
                    end
                end
                W_RESP: begin
                    if (SLAVE_WR_BACK_READY) begin
                        SLAVE_WR_BACK_VALID <= 1'b0;
                        SLAVE_WR_ADDR_READY <= 1'b1;
                        wr_state            <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_t       rd_state;
    logic [ID_W-1:0] rd_id;
    logic [31:0]     rd_addr;
    logic [7:0]      rd_len;
    logic [7:0]      rd_cnt;
    logic [1:0]      rd_burst;
    logic            rd_hit;

    assign rd_hit = in_range(rd_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state            <= R_IDLE;
            rd_id               <= '0;
            rd_addr             <= '0;
            rd_len              <= '0;
            rd_cnt              <= '0;
            rd_burst            <= '0;
            SLAVE_RD_ADDR_READY <= 1'b0;
            SLAVE_RD_BACK_ID    <= '0;
            SLAVE_RD_DATA       <= '0;
            SLAVE_RD_DATA_RESP  <= '0;
            SLAVE_RD_DATA_LAST  <= 1'b0;
            SLAVE_RD_DATA_VALID <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (SLAVE_RD_ADDR_VALID && SLAVE_RD_ADDR_READY) begin
                        rd_id               <= SLAVE_RD_ADDR_ID;
                        rd_addr             <= SLAVE_RD_ADDR;
                        rd_len              <= SLAVE_RD_ADDR_LEN;
                        rd_burst            <= SLAVE_RD_ADDR_BURST;
                        rd_cnt              <= '0;
                        SLAVE_RD_ADDR_READY <= 1'b0;
                        rd_state            <= R_FETCH;
                    end else begin
                        SLAVE_RD_ADDR_READY <= 1'b1;
                    end
                end
                R_FETCH: begin
                    // Same-edge writes land after this read: old data is returned.
                    SLAVE_RD_DATA       <= rd_hit ? mem[rd_addr[ADDR_W-1:0]] : 32'd0;
                    SLAVE_RD_DATA_RESP  <= !rd_hit            ? RESP_DECERR :
                                           !burst_ok(rd_burst) ? RESP_SLVERR : RESP_OKAY;
                    SLAVE_RD_DATA_LAST  <= (rd_cnt == rd_len);
                    SLAVE_RD_BACK_ID    <= rd_id;
                    SLAVE_RD_DATA_VALID <= 1'b1;
                    rd_state            <= R_DATA;
                end
                R_DATA: begin
                    if (SLAVE_RD_DATA_READY) begin
                        SLAVE_RD_DATA_VALID <= 1'b0;
                        if (SLAVE_RD_DATA_LAST) begin
                            SLAVE_RD_ADDR_READY <= 1'b1;
                            rd_state            <= R_IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + 8'd1;
                            if (rd_burst == BURST_INCR)
                                rd_addr <= rd_addr + 32'd1;
                            rd_state <= R_FETCH;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule
